muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage and sequences multi-cycle M-extension operations. It accepts one operation per start pulse and decodes Funct3 into one of the eight M-extension operations. It runs a radix-2 shift-add multiply or a restoring divide over WIDTH iterations, applies sign correction, and returns the result with a one-cycle done pulse. The pipeline stalls on busy, and flush aborts an in-flight operation.

---
 rtl/muldiv_sequencer.sv | 93 +++++++++
 tb/tb_muldiv_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide (shift-add multiply, restoring divide)
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic sign1, sign2;
  logic [WIDTH-1:0] opnd;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH:0] rem, mul_sum;
  logic [WIDTH+1:0] trial;
  logic s1_in, s2_in, div_zero, ovf, special, accept;
  logic [WIDTH-1:0] m1, m2, special_val, quo, rmd, fix_val;
  always_comb begin
    s1_in = (Funct3 == 3'b001 || Funct3 == 3'b010 || Funct3 == 3'b100 || Funct3 == 3'b110) && operand1[WIDTH-1];
    s2_in = (Funct3 == 3'b001 || Funct3 == 3'b100 || Funct3 == 3'b110) && operand2[WIDTH-1];
    m1 = s1_in ? -operand1 : operand1;
    m2 = s2_in ? -operand2 : operand2;
    div_zero = Funct3[2] && operand2 == '0;
    ovf = (Funct3 == 3'b100 || Funct3 == 3'b110) && operand1 == {1'b1, {(WIDTH-1){1'b0}}} && operand2 == '1;
    special = div_zero || ovf;
    special_val = div_zero ? (Funct3[1] ? operand1 : '1) : (Funct3[1] ? '0 : operand1);
    accept = state == IDLE && start && !flush;
  end
  // multiply: opnd is the multiplicand, prod low half holds the multiplier;
  // divide: opnd is the divisor, prod low half shifts dividend bits out and quotient bits in
  always_comb begin
    mul_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, prod[0] ? opnd : '0};
    trial = {rem, prod[WIDTH-1]} - {2'b0, opnd};
    prod_fix = (sign1 ^ sign2) ? -prod : prod;
    quo = (sign1 ^ sign2) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rmd = sign1 ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    fix_val = f3[2] ? (f3[1] ? rmd : quo) :
              (f3[1:0] == 2'b00 ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = accept ? (special ? DONE : CALC) : IDLE;
      CALC:    next = flush ? IDLE : (cnt == CW'(WIDTH-1) ? FIXUP : CALC);
      FIXUP:   next = flush ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    done = state == DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      cnt    <= '0;
      f3     <= '0;
      sign1  <= 1'b0;
      sign2  <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
      rem    <= '0;
      result <= '0;
    end else if (accept) begin
      cnt   <= '0;
      f3    <= Funct3;
      sign1 <= s1_in;
      sign2 <= s2_in;
      opnd  <= Funct3[2] ? m2 : m1;
      prod  <= {{WIDTH{1'b0}}, Funct3[2] ? m1 : m2};
      rem   <= '0;
      if (special) result <= special_val;
    end else if (state == CALC) begin
      cnt <= cnt + 1'b1;
      if (!f3[2]) prod <= {mul_sum, prod[WIDTH-1:1]};
      else begin
        rem <= trial[WIDTH+1] ? {rem[WIDTH-1:0], prod[WIDTH-1]} : trial[WIDTH:0];
        prod[WIDTH-1:0] <= {prod[WIDTH-2:0], ~trial[WIDTH+1]};
      end
    end else if (state == FIXUP && !flush) result <= fix_val;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: randomized and directed checks of muldiv_sequencer against an arithmetic model
module tb_muldiv_sequencer;
  logic clk = 1'b0, rst, start, flush;
  logic [2:0] f3;
  logic [31:0] a, b, result;
  logic busy, done;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .Funct3(f3),
    .operand1(a), .operand2(b), .busy(busy), .done(done), .result(result)
  );
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] ss, su;
    logic [63:0] uu;
    logic signed [31:0] sx, sy;
    logic o;
    ss = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
    su = $signed({{32{x[31]}}, x}) * $signed({32'b0, y});
    uu = {32'b0, x} * {32'b0, y};
    sx = x;
    sy = y;
    o = x == 32'h8000_0000 && y == 32'hFFFF_FFFF;
    case (f)
      3'd0: return uu[31:0];
      3'd1: return ss[63:32];
      3'd2: return su[63:32];
      3'd3: return uu[63:32];
      3'd4: if (y == 0) return 32'hFFFF_FFFF; else if (o) return x; else return sx / sy;
      3'd5: if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      3'd6: if (y == 0) return x; else if (o) return 32'd0; else return sx % sy;
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction
  function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction
  // starts an op at the current negedge, scrambles the inputs after acceptance,
  // and returns latency, busy-throughout flag, result in DONE and busy one cycle later
  task automatic run(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                     output int lat, output bit bok, output logic [31:0] res, output logic pbusy);
    f3 = f; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; f3 = 3'($urandom); a = $urandom; b = $urandom;
    lat = 1; bok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) bok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) bok = 1'b0;
    res = result;
    @(negedge clk);
    pbusy = busy;
  endtask
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_directed;
    logic [2:0] fv [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] xv [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] yv [12] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                             32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ev [12] = '{32'hFFFF_FFCF, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int lv [12] = '{34, 34, 34, 34, 34, 34, 34, 34, 1, 1, 1, 1};
    int lat; bit bok; logic [31:0] res; logic pb;
    for (int i = 0; i < 12; i++) begin
      run(fv[i], xv[i], yv[i], lat, bok, res, pb);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, ev[i]); end
      checks++; if (lat != lv[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, lv[i]); end
      checks++; if (!bok) begin errors++; $display("FAIL dir%0d_busy_during got=0 exp=1", i); end
      checks++; if (pb !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_after got=%b exp=0", i, pb); end
    end
  endtask
  task automatic test_random;
    int lat; bit bok; logic [31:0] res, x, y; logic pb; logic [2:0] f;
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 0;
        1: y = $urandom_range(1, 20);
        2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run(f, x, y, lat, bok, res, pb);
      checks++; if (res !== model(f, x, y)) begin errors++; $display("FAIL rnd%0d_result f=%0d a=%h b=%h got=%h exp=%h", i, f, x, y, res, model(f, x, y)); end
      checks++; if (lat != model_lat(f, x, y)) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, model_lat(f, x, y)); end
      checks++; if (!bok || pb !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy got=%b/%b exp=1/0", i, bok, pb); end
    end
  endtask
  task automatic test_ignore_and_flush;
    int lat; bit bok, seen; logic [31:0] res; logic pb;
    f3 = 3'd0; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    a = 32'd11; b = 32'd13; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 6;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lat != 34) begin errors++; $display("FAIL ignore_latency got=%0d exp=34", lat); end
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL ignore_result got=%h exp=%h", result, 32'd15); end
    @(negedge clk);
    f3 = 3'd0; a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 1'b0;
    repeat (9) begin if (done) seen = 1'b1; @(negedge clk); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0 || seen) begin errors++; $display("FAIL flush_done got=%b/%b exp=0/0", done, seen); end
    checks++; if (result !== 32'd15) begin errors++; $display("FAIL flush_result got=%h exp=%h", result, 32'd15); end
    run(3'd5, 32'd100, 32'd7, lat, bok, res, pb);
    checks++; if (res !== 32'd14 || lat != 34) begin errors++; $display("FAIL after_flush got=%h/%0d exp=%h/34", res, lat, 32'd14); end
    f3 = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got=%b exp=0", busy); end
    seen = 1'b0;
    repeat (40) begin if (done || busy) seen = 1'b1; @(negedge clk); end
    checks++; if (seen || result !== 32'd14) begin errors++; $display("FAIL start_flush_idle got=%b/%h exp=0/%h", seen, result, 32'd14); end
  endtask
  task automatic test_rst_mid;
    int lat; bit bok; logic [31:0] res; logic pb;
    f3 = 3'd0; a = 32'd6; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got=%h exp=0", result); end
    run(3'd5, 32'd9, 32'd3, lat, bok, res, pb);
    checks++; if (res !== 32'd3) begin errors++; $display("FAIL rst_then_divu got=%h exp=%h", res, 32'd3); end
    checks++; if (lat != 34) begin errors++; $display("FAIL rst_then_divu_latency got=%0d exp=34", lat); end
  endtask
  task automatic test_back_to_back;
    int d [2] = '{-1, -1};
    int n = 0, t = 0;
    f3 = 3'd0; a = 32'd9; b = 32'd9; start = 1'b1;
    while (n < 2 && t < 200) begin
      @(negedge clk);
      t++;
      if (done) begin d[n] = t; n++; end
    end
    start = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++; if (d[0] != 34) begin errors++; $display("FAIL b2b_first got=%0d exp=34", d[0]); end
    checks++; if (d[1] - d[0] != 35) begin errors++; $display("FAIL b2b_spacing got=%0d exp=35", d[1] - d[0]); end
    checks++; if (result !== 32'd81 || busy !== 1'b0) begin errors++; $display("FAIL b2b_flush_in_done got=%h/%b exp=%h/0", result, busy, 32'd81); end
  endtask
  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_and_flush;
    test_rst_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
